// File: rtl/tx_axis_frame_arbiter.sv
// Frame-level round-robin arbiter sharing the MAC TX AXIS port among C_NUM_SRC sources (ARB_WDOG_EN adds a stall watchdog).
// Latency: request seen in IDLE -> grant next cycle; data/valid/last/ready are combinational pass-through while granted.
// Backpressure: granted source's tready mirrors MAC tready, all others held at 0; at least one idle cycle between frames.
module tx_axis_frame_arbiter #(
  parameter int C_NUM_SRC = 3,
  parameter int C_TIMEOUT = 1000
) (
  input  logic                   tx_mac_aclk,
  input  logic                   tx_mac_reset_n,
  input  logic [8*C_NUM_SRC-1:0] s_axis_tdata,
  input  logic [C_NUM_SRC-1:0]   s_axis_tvalid,
  input  logic [C_NUM_SRC-1:0]   s_axis_tlast,
  output logic [C_NUM_SRC-1:0]   s_axis_tready,
  output logic [7:0]             tx_axis_mac_tdata,
  output logic                   tx_axis_mac_tvalid,
  output logic                   tx_axis_mac_tlast,
  input  logic                   tx_axis_mac_tready,
  output logic [C_NUM_SRC-1:0]   arb_grant,
  output logic                   arb_busy,
  output logic                   err_timeout
);

  localparam int PW = (C_NUM_SRC > 1) ? $clog2(C_NUM_SRC) : 1;

`ifdef ARB_WDOG_EN
  localparam int CW = $clog2(C_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, XFER, CLOSE, DRAIN} state_t;
`else
  typedef enum logic {IDLE, XFER} state_t;
`endif

  state_t               state_q, state_d;
  logic [C_NUM_SRC-1:0] grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           g_dat;
  logic                 g_vld, g_lst;
  logic                 req_found;
  logic [PW-1:0]        req_idx;
  logic [PW:0]          cand;

`ifdef ARB_WDOG_EN
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
`endif

  assign g_dat = s_axis_tdata[{gidx_q, 3'b000} +: 8];
  assign g_vld = s_axis_tvalid[gidx_q];
  assign g_lst = s_axis_tlast[gidx_q];

  // Rotating scan: start just past the last owner, wrap at C_NUM_SRC.
  always_comb begin
    req_found = 1'b0;
    req_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= C_NUM_SRC; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(C_NUM_SRC))
        cand = cand - (PW+1)'(C_NUM_SRC);
      if (!req_found && s_axis_tvalid[cand[PW-1:0]]) begin
        req_found = 1'b1;
        req_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    grant_d            = grant_q;
    gidx_d             = gidx_q;
    ptr_d              = ptr_q;
    tx_axis_mac_tdata  = 8'h00;
    tx_axis_mac_tvalid = 1'b0;
    tx_axis_mac_tlast  = 1'b0;
    s_axis_tready      = '0;
`ifdef ARB_WDOG_EN
    cnt_d              = cnt_q;
    err_d              = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_WDOG_EN
        cnt_d = '0;
`endif
        if (req_found) begin
          state_d          = XFER;
          grant_d          = '0;
          grant_d[req_idx] = 1'b1;
          gidx_d           = req_idx;
        end
      end
      XFER: begin
        tx_axis_mac_tdata  = g_dat;
        tx_axis_mac_tvalid = g_vld;
        tx_axis_mac_tlast  = g_lst;
        s_axis_tready      = grant_q & {C_NUM_SRC{tx_axis_mac_tready}};
        if (g_vld && tx_axis_mac_tready && g_lst) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
        end
`ifdef ARB_WDOG_EN
        // Counter tracks consecutive cycles the owner has nothing to offer.
        else if (!g_vld) begin
          if (cnt_q == CW'(C_TIMEOUT - 1)) begin
            state_d = CLOSE;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      CLOSE: begin
        tx_axis_mac_tvalid = 1'b1;
        tx_axis_mac_tlast  = 1'b1;
        if (tx_axis_mac_tready)
          state_d = DRAIN;
      end
      DRAIN: begin
        s_axis_tready = grant_q;
        if (g_vld && g_lst) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_reset_n) begin
    if (!tx_mac_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= PW'(C_NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_WDOG_EN
  always_ff @(posedge tx_mac_aclk or negedge tx_mac_reset_n) begin
    if (!tx_mac_reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign arb_grant = grant_q;
  assign arb_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_tx_axis_frame_arbiter.sv
// Bench for tx_axis_frame_arbiter: drivers push expected MAC beats into a queue, a negedge monitor pops and compares.
module tb_tx_axis_frame_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic [8*N-1:0] s_tdata;
  logic [N-1:0]   s_tvalid, s_tlast, s_tready;
  logic [7:0]     m_tdata;
  logic           m_tvalid, m_tlast;
  logic           m_tready = 1'b1;
  logic [N-1:0]   grant;
  logic           busy, err;

  logic [7:0] src_dat[N];
  logic       src_vld[N];
  logic       src_lst[N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign s_tdata[8*i +: 8] = src_dat[i];
    assign s_tvalid[i]       = src_vld[i];
    assign s_tlast[i]        = src_lst[i];
  end

  tx_axis_frame_arbiter #(.C_NUM_SRC(N), .C_TIMEOUT(TO)) dut (
    .tx_mac_aclk        (clk),
    .tx_mac_reset_n     (rst_n),
    .s_axis_tdata       (s_tdata),
    .s_axis_tvalid      (s_tvalid),
    .s_axis_tlast       (s_tlast),
    .s_axis_tready      (s_tready),
    .tx_axis_mac_tdata  (m_tdata),
    .tx_axis_mac_tvalid (m_tvalid),
    .tx_axis_mac_tlast  (m_tlast),
    .tx_axis_mac_tready (m_tready),
    .arb_grant          (grant),
    .arb_busy           (busy),
    .err_timeout        (err)
  );

  typedef struct {
    int         src;
    logic [7:0] dat;
    logic       lst;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   inv_bad = 0;
  int   err_cnt = 0;
  bit   inv_en = 1'b1;
  bit   chk_idle = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (chk_idle) begin
        chk_idle = 1'b0;
        check("idle_gap_busy", 32'(busy), 32'd0);
        check("idle_gap_tvalid", 32'(m_tvalid), 32'd0);
      end
      if (inv_en && (s_tready !== (grant & {N{m_tready}}))) inv_bad++;
      if (err) err_cnt++;
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data %0h, required no beat", m_tdata);
        end else begin
          e = expq.pop_front();
          check("beat_dat", 32'(m_tdata), 32'(e.dat));
          check("beat_last", 32'(m_tlast), 32'(e.lst));
          check("beat_grant", 32'(grant), 32'(1 << e.src));
          if (e.lst && inv_en) chk_idle = 1'b1;
        end
      end
    end
  end

  task automatic push(input int s, input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.src = s;
      e.dat = 8'(base + i);
      e.lst = (i == len - 1);
      expq.push_back(e);
    end
  endtask

  task automatic push1(input int s, input int d, input logic l);
    exp_t e;
    e.src = s;
    e.dat = 8'(d);
    e.lst = l;
    expq.push_back(e);
  endtask

  task automatic beat(input int s, input logic [7:0] d, input logic l);
    src_dat[s] = d;
    src_lst[s] = l;
    src_vld[s] = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (s_tready[s]) break;
      if (t >= 500) begin
        total++;
        bad++;
        $display("FAIL beat_timeout: src %0d got no ready in 500 cycles, required a handshake", s);
        return;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int base, input int len, input int gap_at, input int gap_len);
    for (int i = 0; i < len; i++) begin
      if (i == gap_at && i > 0) begin
        src_vld[s] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      beat(s, 8'(base + i), (i == len - 1));
    end
    src_vld[s] = 1'b0;
    src_lst[s] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_vld[i] = 1'b0;
      src_lst[i] = 1'b0;
      src_dat[i] = 8'h00;
    end
    m_tready = 1'b1;
    chk_idle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic settle(input string name);
    repeat (5) @(posedge clk);
    check(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    do_reset();
    // Reset holds every output low even with a request pending.
    rst_n = 1'b0;
    src_vld[0] = 1'b1;
    src_dat[0] = 8'h5A;
    src_lst[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", 32'(m_tdata), 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tready", 32'(s_tready), 32'd0);

    // Single source, 60-byte frame.
    do_reset();
    push(1, 0, 60);
    send(1, 0, 60, -1, 0);
    settle("single_done");

    // Contention: expected order 0,1,2,0,1,2.
    do_reset();
    push(0, 8'h10, 10); push(1, 8'h20, 10); push(2, 8'h30, 10);
    push(0, 8'h40, 10); push(1, 8'h50, 10); push(2, 8'h60, 10);
    fork
      begin send(0, 8'h10, 10, -1, 0); send(0, 8'h40, 10, -1, 0); end
      begin send(1, 8'h20, 10, -1, 0); send(1, 8'h50, 10, -1, 0); end
      begin send(2, 8'h30, 10, -1, 0); send(2, 8'h60, 10, -1, 0); end
    join
    settle("contention_done");

    // Backpressure: MAC tready toggling every cycle.
    do_reset();
    push(2, 8'h80, 16);
    fork
      send(2, 8'h80, 16, -1, 0);
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    settle("backpressure_done");

    // Mid-frame gap: src0 holds the grant while src1 waits.
    do_reset();
    push(0, 8'hA0, 10);
    push(1, 8'hB0, 4);
    fork
      send(0, 8'hA0, 10, 5, 50);
      begin
        repeat (3) @(posedge clk);
        #1;
        send(1, 8'hB0, 4, -1, 0);
      end
    join
    settle("gap_done");

    // Reset mid-frame at byte 20, then src0 must win first.
    do_reset();
    for (int k = 0; k < 20; k++) push1(0, k, 1'b0);
    for (int k = 0; k < 20; k++) beat(0, 8'(k), 1'b0);
    src_dat[0] = 8'd20;
    @(negedge clk);
    check("pre_rst_tdata", 32'(m_tdata), 32'd20);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_tdata", 32'(m_tdata), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tready", 32'(s_tready), 32'd0);
    src_vld[0] = 1'b0;
    @(posedge clk);
    #1;
    push(0, 8'hC0, 3); push(1, 8'hD0, 3); push(2, 8'hE0, 3);
    rst_n = 1'b1;
    fork
      send(0, 8'hC0, 3, -1, 0);
      send(1, 8'hD0, 3, -1, 0);
      send(2, 8'hE0, 3, -1, 0);
    join
    settle("post_rst_done");

`ifdef ARB_WDOG_EN
    // Watchdog: src1 stalls 8 cycles after byte 3; rest of its frame is drained.
    do_reset();
    inv_en  = 1'b0;
    err_cnt = 0;
    for (int k = 0; k < 4; k++) push1(1, 8'h40 + k, 1'b0);
    push1(1, 0, 1'b1);
    push(2, 8'h90, 3);
    fork
      send(1, 8'h40, 12, 4, TO);
      send(2, 8'h90, 3, -1, 0);
    join
    settle("wdog_done");
    check("wdog_err_pulses", 32'(err_cnt), 32'd1);
    inv_en = 1'b1;
`else
    check("err_never", 32'(err_cnt), 32'd0);
`endif

    check("ready_invariant", 32'(inv_bad), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
